// File: rtl/id_ex_reg_pkg.sv
// Shared core package: decode select encodings, register constants
// and the control bundle carried from ID into EX.
package id_ex_reg_pkg;

  localparam int ALU_OP_W = 4;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_LUI   = 2'b10,
    EXT_SHAMT = 2'b11
  } ext_sel_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } dst_sel_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: decode fields in, registered EX operands
// and the upstream freeze request out.
interface id_ex_reg_if #(
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [1:0]        ext_sel;
  logic [1:0]        dst_sel;
  logic              uses_rt;
  logic [3:0]        alu_op;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              alu_src;

  logic              hazard_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_dest;
  logic [3:0]        ex_alu_op;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_alu_src;
  logic [15:0]       bubble_cnt;

  modport master (
    output stall, flush, in_valid, instr,
    output rs_data, rt_data, ext_sel, dst_sel,
    output uses_rt, alu_op, reg_write,
    output mem_read, mem_write, alu_src,
    input  hazard_stall, ex_valid,
    input  ex_rs_data, ex_rt_data, ex_imm,
    input  ex_dest, ex_alu_op, ex_reg_write,
    input  ex_mem_read, ex_mem_write, ex_alu_src,
    input  bubble_cnt
  );

  modport slave (
    input  stall, flush, in_valid, instr,
    input  rs_data, rt_data, ext_sel, dst_sel,
    input  uses_rt, alu_op, reg_write,
    input  mem_read, mem_write, alu_src,
    output hazard_stall, ex_valid,
    output ex_rs_data, ex_rt_data, ex_imm,
    output ex_dest, ex_alu_op, ex_reg_write,
    output ex_mem_read, ex_mem_write, ex_alu_src,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg_imm_extend.sv
// Immediate extension: zero, sign, LUI or shamt from the low
// instruction half-word.
module imm_extend
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [IMM_W-1:0]  field,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (sel)
      EXT_ZERO:
        imm = {{(DATA_W-IMM_W){1'b0}}, field};
      EXT_SIGN:
        imm = {{(DATA_W-IMM_W){field[IMM_W-1]}}, field};
      EXT_LUI:
        imm = {field, {(DATA_W-IMM_W){1'b0}}};
      EXT_SHAMT:
        imm = {{(DATA_W-5){1'b0}}, field[10:6]};
    endcase
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with immediate extension, destination
// select and load-use bubble insertion.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input logic         clk,
  input logic         reset,
  id_ex_reg_if.slave  bus
);

  logic [DATA_W-1:0] imm_d;
  logic [4:0]        dest_d;
  ex_ctrl_t          ctrl_d;
  logic              hazard;

  logic              valid_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        dest_q;
  ex_ctrl_t          ctrl_q;
  logic [15:0]       bubble_cnt_q;

  imm_extend #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_imm_extend (
    .field (bus.instr[IMM_W-1:0]),
    .sel   (bus.ext_sel),
    .imm   (imm_d)
  );

  // The reserved select falls back to r0 so it can never write.
  always_comb begin
    dest_d = '0;
    case (bus.dst_sel)
      DST_RT:  dest_d = bus.instr[20:16];
      DST_RD:  dest_d = bus.instr[15:11];
      DST_RA:  dest_d = REG_RA;
      default: dest_d = '0;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    if (bus.in_valid) begin
      ctrl_d.alu_op    = bus.alu_op;
      ctrl_d.reg_write = bus.reg_write;
      ctrl_d.mem_read  = bus.mem_read;
      ctrl_d.mem_write = bus.mem_write;
      ctrl_d.alu_src   = bus.alu_src;
    end
  end

  assign hazard = valid_q & ctrl_q.mem_read
                & (dest_q != 5'd0) & bus.in_valid
                & ((dest_q == bus.instr[25:21])
                  | (bus.uses_rt
                    & (dest_q == bus.instr[20:16])));

  // Upstream is already frozen under stall, and flush kills the slot.
  assign bus.hazard_stall = hazard & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      dest_q       <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
      ctrl_q  <= '0;
    end else if (bus.stall) begin
      valid_q <= valid_q;
    end else if (hazard) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
      ctrl_q  <= '0;
      if (bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end else begin
      valid_q <= bus.in_valid;
      rs_q    <= bus.rs_data;
      rt_q    <= bus.rt_data;
      imm_q   <= imm_d;
      dest_q  <= dest_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_rs_data   = rs_q;
  assign bus.ex_rt_data   = rt_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_dest      = dest_q;
  assign bus.ex_alu_op    = ctrl_q.alu_op;
  assign bus.ex_reg_write = ctrl_q.reg_write;
  assign bus.ex_mem_read  = ctrl_q.mem_read;
  assign bus.ex_mem_write = ctrl_q.mem_write;
  assign bus.ex_alu_src   = ctrl_q.alu_src;
  assign bus.bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: extension, load-use, stall/flush,
// async reset and counter saturation.
module tb_id_ex_reg;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic done;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    done = 1'b0;
    #100000;
    if (done !== 1'b1) begin
      errors++;
      $error("FAIL timeout: sequence did not complete");
      $finish;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(
    input logic        v,
    input logic [31:0] ins,
    input logic [1:0]  es,
    input logic [1:0]  ds,
    input logic        ur,
    input logic [3:0]  op,
    input logic        rw,
    input logic        mr
  );
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.ext_sel   = es;
    bus.dst_sel   = ds;
    bus.uses_rt   = ur;
    bus.alu_op    = op;
    bus.reg_write = rw;
    bus.mem_read  = mr;
    bus.mem_write = 1'b0;
    bus.alu_src   = 1'b1;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rt);
    drv(1'b1, {6'h23, 5'd0, rt, 16'h0004},
        2'b01, 2'b00, 1'b0, 4'h2, 1'b1, 1'b1);
  endtask

  task automatic add(input logic [4:0] rs,
                     input logic [4:0] rt,
                     input logic [4:0] rd);
    drv(1'b1, {6'h00, rs, rt, rd, 5'd0, 6'h20},
        2'b00, 2'b01, 1'b1, 4'h2, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.rs_data = 32'hA5A5_0001;
    bus.rt_data = 32'h5A5A_0002;
    idle();

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'h0
        || bus.ex_imm !== 32'h0 || bus.ex_reg_write !== 1'b0)
    begin
      errors++;
      $error("FAIL rst_state valid=%0h cnt=%0h imm=%0h rw=%0h",
             bus.ex_valid, bus.bubble_cnt,
             bus.ex_imm, bus.ex_reg_write);
    end

    drv(1'b1, {6'h0d, 5'd1, 5'd2, 16'h8001},
        2'b00, 2'b00, 1'b0, 4'h3, 1'b1, 1'b0);
    @(negedge clk);
    chk("ext_zero", bus.ex_imm, 32'h0000_8001);
    chk("dst_rt", bus.ex_dest, 5'd2);
    chk("cap_valid", bus.ex_valid, 1'b1);
    chk("cap_op", bus.ex_alu_op, 4'h3);
    chk("cap_rs", bus.ex_rs_data, 32'hA5A5_0001);
    bus.ext_sel = 2'b01;
    @(negedge clk);
    chk("ext_sign", bus.ex_imm, 32'hFFFF_8001);
    bus.ext_sel = 2'b10;
    @(negedge clk);
    chk("ext_lui", bus.ex_imm, 32'h8001_0000);
    drv(1'b1, {6'h00, 5'd0, 5'd2, 5'd3, 5'd17, 6'h00},
        2'b11, 2'b01, 1'b0, 4'h5, 1'b1, 1'b0);
    @(negedge clk);
    chk("ext_shamt", bus.ex_imm, 32'h0000_0011);
    chk("dst_rd", bus.ex_dest, 5'd3);
    bus.dst_sel = 2'b10;
    @(negedge clk);
    chk("dst_ra", bus.ex_dest, 5'd31);
    bus.dst_sel = 2'b11;
    @(negedge clk);
    chk("dst_rsv", bus.ex_dest, 5'd0);

    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("inv_valid", bus.ex_valid, 1'b0);
    chk("inv_rw", bus.ex_reg_write, 1'b0);

    lw(5'd8);
    @(negedge clk);
    chk("lw_mr", bus.ex_mem_read, 1'b1);
    chk("lw_dest", bus.ex_dest, 5'd8);
    add(5'd8, 5'd9, 5'd10);
    #1;
    chk("hz_stall", bus.hazard_stall, 1'b1);
    @(negedge clk);
    chk("hz_bub_valid", bus.ex_valid, 1'b0);
    chk("hz_bub_rw", bus.ex_reg_write, 1'b0);
    chk("hz_cnt1", bus.bubble_cnt, 16'd1);
    chk("hz_clear", bus.hazard_stall, 1'b0);
    @(negedge clk);
    chk("hz_add_valid", bus.ex_valid, 1'b1);
    chk("hz_add_dest", bus.ex_dest, 5'd10);
    chk("hz_cnt_keep", bus.bubble_cnt, 16'd1);

    lw(5'd0);
    @(negedge clk);
    add(5'd0, 5'd9, 5'd10);
    #1;
    chk("r0_nostall", bus.hazard_stall, 1'b0);
    @(negedge clk);
    chk("r0_valid", bus.ex_valid, 1'b1);
    chk("r0_cnt", bus.bubble_cnt, 16'd1);

    lw(5'd8);
    @(negedge clk);
    drv(1'b1, {6'h08, 5'd5, 5'd8, 16'h0001},
        2'b01, 2'b00, 1'b0, 4'h1, 1'b1, 1'b0);
    #1;
    chk("rt_nostall", bus.hazard_stall, 1'b0);
    @(negedge clk);
    chk("rt_valid", bus.ex_valid, 1'b1);
    chk("rt_cnt", bus.bubble_cnt, 16'd1);

    bus.stall = 1'b1;
    bus.rs_data = 32'hDEAD_BEEF;
    add(5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 5;
      if (bus.ex_valid !== 1'b1) begin
        errors++;
        $error("FAIL stl_valid %0h", bus.ex_valid);
      end
      if (bus.ex_dest !== 5'd8) begin
        errors++;
        $error("FAIL stl_dest %0h", bus.ex_dest);
      end
      if (bus.ex_imm !== 32'h0000_0001) begin
        errors++;
        $error("FAIL stl_imm %0h", bus.ex_imm);
      end
      if (bus.ex_rs_data !== 32'hA5A5_0001) begin
        errors++;
        $error("FAIL stl_rs %0h", bus.ex_rs_data);
      end
      if (bus.ex_alu_op !== 4'h1) begin
        errors++;
        $error("FAIL stl_op %0h", bus.ex_alu_op);
      end
      bus.instr = bus.instr + 32'h0001_0000;
    end

    bus.stall = 1'b0;
    lw(5'd8);
    @(negedge clk);
    bus.stall = 1'b1;
    add(5'd8, 5'd9, 5'd10);
    #1;
    chk("sh_nostall", bus.hazard_stall, 1'b0);
    @(negedge clk);
    chk("sh_hold_mr", bus.ex_mem_read, 1'b1);
    chk("sh_cnt", bus.bubble_cnt, 16'd1);
    bus.stall = 1'b0;
    #1;
    chk("sh_rel_stall", bus.hazard_stall, 1'b1);
    @(negedge clk);
    chk("sh_bub", bus.ex_valid, 1'b0);
    chk("sh_cnt2", bus.bubble_cnt, 16'd2);
    @(negedge clk);
    chk("sh_add_rw", bus.ex_reg_write, 1'b1);

    lw(5'd4);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", bus.ex_valid, 1'b0);
    chk("fl_rw", bus.ex_reg_write, 1'b0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    lw(5'd8);
    @(negedge clk);
    add(5'd8, 5'd9, 5'd10);
    @(negedge clk);
    chk("rb_cnt3", bus.bubble_cnt, 16'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_cnt0", bus.bubble_cnt, 16'd0);
    chk("rb_valid", bus.ex_valid, 1'b0);
    chk("rb_mr", bus.ex_mem_read, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b0;

    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    @(negedge clk);
    chk("sat_pre", bus.bubble_cnt, 16'hFFFE);
    lw(5'd8);
    @(negedge clk);
    add(5'd8, 5'd9, 5'd10);
    @(negedge clk);
    chk("sat_max", bus.bubble_cnt, 16'hFFFF);
    @(negedge clk);
    lw(5'd7);
    @(negedge clk);
    add(5'd1, 5'd7, 5'd2);
    #1;
    chk("sat_stall", bus.hazard_stall, 1'b1);
    @(negedge clk);
    chk("sat_hold", bus.bubble_cnt, 16'hFFFF);
    chk("sat_bub", bus.ex_valid, 1'b0);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the MIPS32 core, with the immediate extension unit and the load-use hazard detector folded in. It takes the decoded instruction, register-file read data and control bits from decode and forms the 32-bit immediate: zero, sign, LUI or shamt. It also selects the destination register and presents all of it, registered, to the execute stage. It inserts one bubble on a load-use hazard and requests an upstream freeze, honours external stall and flush, and counts inserted bubbles.

## Interface
- DATA_W, 32, datapath width
- IMM_W, 16, instruction immediate width
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all EX-side registers (memory stall)
- flush  in  1  kill the instruction being captured (branch/jump redirect)
- in_valid  in  1  decode slot holds a real instruction
- instr  in  32  instruction word from IF/ID
- rs_data, rt_data  in  DATA_W  register-file read data
- ext_sel  in  2  00 zero, 01 sign, 10 LUI, 11 shamt
- dst_sel  in  2  00 rt, 01 rd, 10 r31, 11 reserved (treated as r0)
- uses_rt  in  1  instruction reads rt as a source
- alu_op  in  4  ALU operation code
- reg_write, mem_read, mem_write, alu_src  in  1 each  control bits
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_dest  out  5  registered destination register
- ex_alu_op  out  4; ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each
- bubble_cnt  out  16  saturating count of hazard bubbles

## Operation
- Extension uses imm = instr[15:0]:
  - zero: {16'b0, imm}
  - sign: {{16{imm[15]}}, imm}
  - LUI: {imm, 16'b0}
  - shamt: {27'b0, instr[10:6]}
- Destination: rt = instr[20:16], rd = instr[15:11], r31 = 5'd31.
- Hazard condition: ex_valid & ex_mem_read & ex_dest != 0 & in_valid & (ex_dest == instr[25:21] | (uses_rt & ex_dest == instr[20:16])).
- hazard_stall = hazard & !stall & !flush.
- Per-edge priority, highest first:
  1. flush: load a bubble.
  2. stall: hold every register.
  3. hazard: load a bubble and increment bubble_cnt.
  4. otherwise: capture the inputs, with ex_valid = in_valid.
- A bubble sets ex_valid = 0 and all control outputs to 0, and clears data, imm and dest to 0.
- If in_valid = 0, the controls are captured as 0, so an invalid slot never writes.
- bubble_cnt saturates at 16'hFFFF and never wraps. Only reset clears it.
- Reset, asynchronous: every output register goes to 0, giving ex_valid = 0 and bubble_cnt = 0. Asserting reset mid-stall or mid-bubble discards all state immediately.

## Timing
- Latency is 1 cycle from decode inputs to the ex_* outputs.
- hazard_stall is a same-cycle combinational output from the current ex_* state and the inputs. Upstream holds IF/ID exactly one cycle per hazard.
- After the bubble, the dependent instruction is re-presented and captured on the next edge. At that point ex_mem_read = 0, so no second bubble occurs.
- stall and flush together: flush wins and the EX slot becomes a bubble.
- stall together with a hazard: hold, with no bubble and no count. hazard_stall = 0 because upstream is already frozen by stall.
- No combinational path from inputs to ex_* outputs.

## Structure
- Shared core package holds:
  - ext_sel encodings EXT_ZERO/EXT_SIGN/EXT_LUI/EXT_SHAMT
  - dst_sel encodings DST_RT/DST_RD/DST_RA
  - constant REG_RA = 5'd31
  - the ALU op width
- One sub-module: imm_extend, which is combinational and maps (instr, ext_sel) to a 32-bit immediate and replaces the standalone zero-extend use in decode.
- Hazard compare and the register bank live in id_ex_reg.

## Test plan
- Extension: imm = 16'h8001:
  - ext_sel 00 → ex_imm = 32'h0000_8001 one cycle later
  - 01 → 32'hFFFF_8001
  - 10 → 32'h8001_0000
  - instr[10:6] = 5'd17 with 11 → 32'h0000_0011
- Load-use:
  - lw with rt = 8 captured, then add with rs = 8 presented → hazard_stall = 1 that cycle
  - next cycle ex_valid = 0 and bubble_cnt = 1
  - add is captured the following edge with ex_valid = 1
- Hazard is suppressed in two cases:
  - same sequence but the load's dest = r0 → no hazard_stall, no bubble
  - uses_rt = 0 with only the rt match → no hazard_stall
- Stall/flush:
  - stall held 3 cycles → all ex_* outputs constant
  - flush together with stall → ex_valid = 0 and ex_reg_write = 0 next edge
- Reset and saturation:
  - assert reset asynchronously mid-cycle during a bubble → all outputs 0 before the next edge
  - drive bubble_cnt to 16'hFFFF, force one more hazard → count stays at 16'hFFFF
